frame_deserializer: RTL
=======================

Name: frame_deserializer

Overview:
- Parametrised successor to the 3-byte operand/opcode demultiplexer.
- Collects a frame from a byte-strobed input stream: NUM_OPERANDS operand words, then one opcode word.
- Presents the complete frame in parallel with a valid/ack handshake toward the ALU/dispatch stage.
- Adds what the fixed 3x8 block lacks: parametrised width and operand count, output hold until acknowledged, overrun detection, inter-byte timeout and flush.

Parameters:
- DATA_W, 8, width of each input word, each operand and the opcode.
- NUM_OPERANDS, 2, operand words per frame before the opcode word; legal range 1..15.
- TIMEOUT_CYCLES, 0, idle cycles allowed between words of a partial frame before it is discarded; 0 disables the timeout.

Ports:
- i_clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_ready  input  1  word strobe; i_data is valid in this cycle.
- i_data  input  DATA_W  incoming word.
- i_flush  input  1  synchronous discard of any partial frame and any held frame.
- i_ack  input  1  consumer accepts the held frame.
- o_valid  output  1  complete frame held on o_operands/o_opcode.
- o_operands  output  NUM_OPERANDS*DATA_W  operand k at bits [k*DATA_W +: DATA_W]; operand 0 is the first word received.
- o_opcode  output  DATA_W  last word of the frame.
- o_busy  output  1  partial frame in progress.
- o_word_idx  output  4  index of the next expected word: 0..NUM_OPERANDS, where NUM_OPERANDS means opcode.
- o_overrun  output  1  one-cycle pulse when a word is dropped.
- o_timeout  output  1  one-cycle pulse when a partial frame is discarded by timeout.

Behaviour:
- Reset (sync, highest priority): all outputs 0, all operand/opcode registers 0, state IDLE, idle counter 0. Reset mid-frame discards the frame, with no pulse.
- States:
  - IDLE: o_valid=0, o_busy=0.
  - COLLECT: o_busy=1.
  - HOLD: o_valid=1.
- IDLE with i_ready: store word into operand 0 (or opcode when NUM_OPERANDS is irrelevant — never, since the minimum is 1), set idx=1, go to COLLECT.
- COLLECT with i_ready:
  - idx<NUM_OPERANDS: store into operand[idx], idx++.
  - idx==NUM_OPERANDS: store opcode, idx=0, go to HOLD.
- Latency: o_valid rises the cycle after the opcode strobe. There is no valid gap between back-to-back frames except as set by the ack rules below.
- HOLD:
  - Outputs are stable while o_valid=1.
  - i_ack=1: o_valid falls next cycle.
  - i_ack=1 and i_ready=1 in the same cycle: the word is captured as word 0 of the next frame; next state is COLLECT, idx=1, o_valid=0.
  - i_ready=1 without i_ack: the word is dropped, o_overrun pulses next cycle, and the held frame is unchanged.
- i_ack outside HOLD is ignored.
- Timeout (TIMEOUT_CYCLES>0, COLLECT only):
  - The idle counter clears on every i_ready and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, idx=0, o_timeout pulses next cycle.
  - A word arriving in the same cycle the count is reached is accepted and the timeout is cancelled.
- i_flush (below reset, above everything else):
  - Next state IDLE, o_valid=0, idx=0, no pulses.
  - A word strobed in the same cycle is dropped silently.
  - Operand/opcode registers keep their last values.
- Once in HOLD, o_operands/o_opcode change only on capture of a new frame's words.
- Pulses never stretch; o_overrun and o_timeout cannot both assert in the same cycle.
- The opcode value is not interpreted; the frame length is fixed by NUM_OPERANDS.

Test Plan:
- Defaults; strobe 0x12, 0x34, 0xA5 on consecutive cycles -> o_valid=1 the cycle after 0xA5; o_operands=0x3412; o_opcode=0xA5; o_busy drops with valid.
- Frame held, no ack; strobe 0x77 -> o_overrun single pulse, outputs unchanged; then ack with strobe 0x01 -> o_valid=0, o_busy=1, o_word_idx=1.
- TIMEOUT_CYCLES=4; strobe 0x10, then idle 4 cycles -> o_timeout pulse, o_word_idx=0; next frame 0x01, 0x02, 0x03 -> o_operands=0x0201, o_opcode=0x03.
- DATA_W=16, NUM_OPERANDS=3; words 0x1111, 0x2222, 0x3333, 0x00FF -> o_operands=0x333322221111, o_opcode=0x00FF.
- Assert i_flush after 2 words -> IDLE, no o_valid; a following 3-word frame decodes correctly.
- Assert reset during HOLD and during COLLECT -> all outputs 0 the next cycle; subsequent frame decodes correctly.

Source files
------------

// File: rtl/frame_deserializer.sv
// Byte-strobed frame collector: NUM_OPERANDS operand words then one opcode word,
// presented in parallel and held until acknowledged, with overrun, timeout and flush.
module frame_deserializer #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned NUM_OPERANDS   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                           i_clk,
  input  logic                           reset,
  input  logic                           i_ready,
  input  logic [DATA_W-1:0]              i_data,
  input  logic                           i_flush,
  input  logic                           i_ack,
  output logic                           o_valid,
  output logic [NUM_OPERANDS*DATA_W-1:0] o_operands,
  output logic [DATA_W-1:0]              o_opcode,
  output logic                           o_busy,
  output logic [3:0]                     o_word_idx,
  output logic                           o_overrun,
  output logic                           o_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_OPERANDS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_e;

  state_e                         state_q, state_d;
  logic [3:0]                     idx_q, idx_d;
  logic [NUM_OPERANDS*DATA_W-1:0] operands_q, operands_d;
  logic [DATA_W-1:0]              opcode_q, opcode_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           overrun_q, overrun_d;
  logic                           timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    operands_d = operands_q;
    opcode_d   = opcode_q;
    cnt_d      = '0;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;
    if (i_flush) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_ready) begin
            operands_d[DATA_W-1:0] = i_data;
            idx_d   = 4'd1;
            state_d = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (i_ready) begin
            if (idx_q == LAST_IDX) begin
              opcode_d = i_data;
              idx_d    = '0;
              state_d  = S_HOLD;
            end else begin
              for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
                if (idx_q == 4'(k)) operands_d[k*DATA_W +: DATA_W] = i_data;
              end
              idx_d = idx_q + 4'd1;
            end
          end else if (TIMEOUT_CYCLES > 0) begin
            // The counter holds the idle cycles already seen, so the check fires on the last allowed one.
            if (cnt_q == CNT_LAST) begin
              state_d   = S_IDLE;
              idx_d     = '0;
              timeout_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (i_ack) begin
            if (i_ready) begin
              operands_d[DATA_W-1:0] = i_data;
              idx_d   = 4'd1;
              state_d = S_COLLECT;
            end else begin
              state_d = S_IDLE;
            end
          end else if (i_ready) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      operands_q <= '0;
      opcode_q   <= '0;
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      operands_q <= operands_d;
      opcode_q   <= opcode_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_valid    = (state_q == S_HOLD);
  assign o_busy     = (state_q == S_COLLECT);
  assign o_word_idx = idx_q;
  assign o_operands = operands_q;
  assign o_opcode   = opcode_q;
  assign o_overrun  = overrun_q;
  assign o_timeout  = timeout_q;

endmodule
